nibble_serial_mac: RTL and testbench

- Sequential 16x16 unsigned multiply-accumulate controller for DNN dot products; sits directly downstream of the sixteen_four 16x4 partial-product stage and drives its operands.
- Takes one (activation, weight) pair per element. Feeds the 4-bit weight nibbles to sixteen_four one at a time and shift-accumulates the 20-bit results into a 32-bit product.
- Adds each product into a running dot-product sum and emits the sum when the last element is flagged.

---
 rtl/nibble_serial_mac_if.sv | 30 +++
 rtl/nibble_serial_mac.sv | 121 ++++++++++++
 tb/tb_nibble_serial_mac.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_mac_if.sv
// Operand, multiplier and result bundle between a producer, the nibble-serial MAC
// and its sixteen_four partial-product stage.
interface nibble_serial_mac_if #(
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_w;
  logic             in_last;
  logic [15:0]      mul_a;
  logic [3:0]       mul_b;
  logic [19:0]      mul_pp;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;

  // master: producer/consumer and multiplier side
  modport master (
    output in_valid, in_a, in_w, in_last, mul_pp, res_ready,
    input  in_ready, mul_a, mul_b, res_valid, res_data, res_ovf
  );

  // slave: the MAC controller
  modport slave (
    input  in_valid, in_a, in_w, in_last, mul_pp, res_ready,
    output in_ready, mul_a, mul_b, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/nibble_serial_mac.sv
// Nibble-serial 16x16 unsigned MAC: drives sixteen_four one weight nibble at a time,
// accumulates a dot product. Define SAT_MAC_EN for a saturating accumulator.
module nibble_serial_mac #(
  parameter int ACC_W   = 40,
  parameter int MUL_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_mac_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_OUT} state_t;

  localparam int         SUM_W     = ACC_W + 1;
  localparam logic [1:0] HOLD_LAST = 2'(MUL_LAT);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_idx;
  logic [1:0]       r_hold;
  logic [15:0]      r_mul_a;
  logic [15:0]      r_w;
  logic             r_last;
  logic             r_in_ready;
  logic             r_ovf;
  logic [31:0]      r_prod;
  logic [ACC_W-1:0] r_acc;

  logic             w_accept;
  logic             w_hold_done;
  logic [31:0]      w_pp_shifted;
  logic [SUM_W-1:0] w_sum;
  logic             w_carry;

  assign w_accept     = bus.in_valid & r_in_ready;
  assign w_hold_done  = (r_hold == HOLD_LAST);
  assign w_pp_shifted = {12'd0, bus.mul_pp} << {r_idx, 2'b00};
  assign w_sum        = {1'b0, r_acc} + SUM_W'(r_prod);
  assign w_carry      = w_sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_MUL;
      S_MUL:  if (w_hold_done && (r_idx == 2'd3)) w_state_next = S_ADD;
      S_ADD:  w_state_next = r_last ? S_OUT : S_IDLE;
      S_OUT:  if (bus.res_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state, so it first rises one edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 2'd0;
      r_hold     <= 2'd0;
      r_mul_a    <= 16'd0;
      r_w        <= 16'd0;
      r_last     <= 1'b0;
      r_in_ready <= 1'b0;
      r_ovf      <= 1'b0;
      r_prod     <= 32'd0;
      r_acc      <= '0;
    end else begin
      r_in_ready <= (w_state_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mul_a <= bus.in_a;
            r_w     <= bus.in_w;
            r_last  <= bus.in_last;
            r_prod  <= 32'd0;
            r_idx   <= 2'd0;
            r_hold  <= 2'd0;
          end
        end
        S_MUL: begin
          if (w_hold_done) begin
            r_hold <= 2'd0;
            r_prod <= r_prod + w_pp_shifted;
            r_idx  <= r_idx + 2'd1;
          end else begin
            r_hold <= r_hold + 2'd1;
          end
        end
        S_ADD: begin
`ifdef SAT_MAC_EN
          r_acc <= w_carry ? '1 : w_sum[ACC_W-1:0];
`else
          r_acc <= w_sum[ACC_W-1:0];
`endif
          r_ovf <= r_ovf | w_carry;
        end
        S_OUT: begin
          if (bus.res_ready) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = (r_state == S_MUL) ? r_w[{r_idx, 2'b00} +: 4] : 4'd0;
  assign bus.res_valid = (r_state == S_OUT);
  assign bus.res_data  = r_acc;
  assign bus.res_ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_mac.sv
// Directed bench for nibble_serial_mac: three instances (ACC_W=40/MUL_LAT=0,
// ACC_W=32/MUL_LAT=0, ACC_W=40/MUL_LAT=2) each with a behavioural sixteen_four.
module tb_nibble_serial_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_mac_if #(.ACC_W(40)) bus0 ();
  nibble_serial_mac_if #(.ACC_W(32)) bus1 ();
  nibble_serial_mac_if #(.ACC_W(40)) bus2 ();

  nibble_serial_mac #(.ACC_W(40), .MUL_LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  nibble_serial_mac #(.ACC_W(32), .MUL_LAT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  nibble_serial_mac #(.ACC_W(40), .MUL_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  logic        vld[3], lst[3], rrdy[3];
  logic [15:0] ain[3], win[3], sent_w[3];
  logic        rdy[3], rv[3], ovf[3];
  logic [63:0] rd[3];
  logic [3:0]  mb[3];
  logic [15:0] ma0;
  int          acc_cyc[3], res_cyc[3];

  assign bus0.in_valid = vld[0];  assign bus0.in_a = ain[0];  assign bus0.in_w = win[0];
  assign bus0.in_last  = lst[0];  assign bus0.res_ready = rrdy[0];
  assign bus1.in_valid = vld[1];  assign bus1.in_a = ain[1];  assign bus1.in_w = win[1];
  assign bus1.in_last  = lst[1];  assign bus1.res_ready = rrdy[1];
  assign bus2.in_valid = vld[2];  assign bus2.in_a = ain[2];  assign bus2.in_w = win[2];
  assign bus2.in_last  = lst[2];  assign bus2.res_ready = rrdy[2];

  assign rdy[0] = bus0.in_ready;  assign rv[0] = bus0.res_valid;  assign ovf[0] = bus0.res_ovf;
  assign rdy[1] = bus1.in_ready;  assign rv[1] = bus1.res_valid;  assign ovf[1] = bus1.res_ovf;
  assign rdy[2] = bus2.in_ready;  assign rv[2] = bus2.res_valid;  assign ovf[2] = bus2.res_ovf;
  assign rd[0]  = 64'(bus0.res_data);
  assign rd[1]  = 64'(bus1.res_data);
  assign rd[2]  = 64'(bus2.res_data);
  assign mb[0]  = bus0.mul_b;  assign mb[1] = bus1.mul_b;  assign mb[2] = bus2.mul_b;
  assign ma0    = bus0.mul_a;

  // sixteen_four models: combinational for MUL_LAT=0, two register stages for MUL_LAT=2
  logic [19:0] pp2_d1, pp2_d2;
  assign bus0.mul_pp = 20'(bus0.mul_a) * 20'(bus0.mul_b);
  assign bus1.mul_pp = 20'(bus1.mul_a) * 20'(bus1.mul_b);
  always @(posedge clk) begin
    pp2_d1 <= 20'(bus2.mul_a) * 20'(bus2.mul_b);
    pp2_d2 <= pp2_d1;
  end
  assign bus2.mul_pp = pp2_d2;

  function automatic int lat_of(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] w, input logic last);
    int n = 0;
    ain[i] = a; win[i] = w; lst[i] = last; vld[i] = 1'b1;
    while (rdy[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", 64'(rdy[i]), 64'd1);
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
    sent_w[i] = w;
    acc_cyc[i] = cyc;
    $display("accept inst=%0d a=%h w=%h last=%0b cyc=%0d", i, a, w, last, cyc);
  endtask

  // Called right after an accept edge: checks nibble sequence, latency, result and handshake.
  task automatic get_res(input int i, input logic [63:0] exp_d, input logic exp_o, input int hold);
    int k = 0;
    int lt = lat_of(i);
    logic [15:0] w = sent_w[i];
    logic [3:0] en;
    while (k < 200 && rv[i] !== 1'b1) begin
      @(negedge clk);
      k++;
      if (k <= 4 * (lt + 1)) begin
        en = w[4 * ((k - 1) / (lt + 1)) +: 4];
        chk("mul_b_nibble", 64'(mb[i]), 64'(en));
      end
    end
    chk("res_latency", 64'(k), 64'(4 * (lt + 1) + 2));
    chk("res_data", rd[i], exp_d);
    chk("res_ovf", 64'(ovf[i]), 64'(exp_o));
    chk("mul_b_out_zero", 64'(mb[i]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_res_data", rd[i], exp_d);
      chk("hold_res_valid", 64'(rv[i]), 64'd1);
      chk("hold_in_ready", 64'(rdy[i]), 64'd0);
    end
    rrdy[i] = 1'b1;
    @(posedge clk);
    #1;
    res_cyc[i] = cyc;
    rrdy[i] = 1'b0;
    $display("result inst=%0d data=%h ovf=%0b latency=%0d cyc=%0d", i, exp_d, exp_o, k, cyc);
    @(negedge clk);
    chk("post_res_valid", 64'(rv[i]), 64'd0);
    chk("post_res_data", rd[i], 64'd0);
    chk("post_res_ovf", 64'(ovf[i]), 64'd0);
    chk("post_in_ready", 64'(rdy[i]), 64'd1);
  endtask

  initial begin
    int prev;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; lst[i] = 1'b0; rrdy[i] = 1'b0;
      ain[i] = 16'd0; win[i] = 16'd0; sent_w[i] = 16'd0;
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(rdy[0]), 64'd0);
    chk("rst_mul_a", 64'(ma0), 64'd0);
    chk("rst_mul_b", 64'(mb[0]), 64'd0);
    chk("rst_res_valid", 64'(rv[0]), 64'd0);
    chk("rst_res_data", rd[0], 64'd0);
    chk("rst_res_ovf", 64'(ovf[0]), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", 64'(rdy[0]), 64'd0);
    @(negedge clk);
    chk("in_ready_after_first_edge", 64'(rdy[0]), 64'd1);

    // single element, max operands
    send(0, 16'hFFFF, 16'hFFFF, 1'b1);
    get_res(0, 64'hFFFE_0001, 1'b0, 0);

    // three-element dot product, producer always offering
    send(0, 16'd2, 16'd3, 1'b0);
    prev = acc_cyc[0];
    send(0, 16'd4, 16'd5, 1'b0);
    chk("accept_spacing_1", 64'(acc_cyc[0] - prev), 64'd6);
    prev = acc_cyc[0];
    send(0, 16'd6, 16'd7, 1'b1);
    chk("accept_spacing_2", 64'(acc_cyc[0] - prev), 64'd6);
    get_res(0, 64'd68, 1'b0, 0);

    // back-pressure with the next element already waiting
    send(0, 16'd7, 16'd9, 1'b1);
    ain[0] = 16'd3; win[0] = 16'd4; lst[0] = 1'b1; vld[0] = 1'b1;
    get_res(0, 64'd63, 1'b0, 5);
    send(0, 16'd3, 16'd4, 1'b1);
    chk("accept_after_res_handshake", 64'(acc_cyc[0] - res_cyc[0]), 64'd1);
    get_res(0, 64'd12, 1'b0, 0);

    // 32-bit accumulator overflow, then sticky flag cleared for the next dot product
    send(1, 16'hFFFF, 16'hFFFF, 1'b0);
    send(1, 16'hFFFF, 16'hFFFF, 1'b1);
`ifdef SAT_MAC_EN
    get_res(1, 64'hFFFF_FFFF, 1'b1, 0);
`else
    get_res(1, 64'hFFFC_0002, 1'b1, 0);
`endif
    send(1, 16'd1, 16'd1, 1'b1);
    get_res(1, 64'd1, 1'b0, 0);

    // MUL_LAT=2: each nibble held three cycles, 14-cycle latency
    send(2, 16'h1234, 16'hA5C3, 1'b1);
    get_res(2, 64'h0BC9_619C, 1'b0, 0);

    // reset during the second nibble discards partial sum and product
    send(0, 16'd100, 16'd100, 1'b0);
    send(0, 16'h1111, 16'h2222, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midop_mul_b_nibble1", 64'(mb[0]), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(rdy[0]), 64'd0);
    chk("midrst_mul_a", 64'(ma0), 64'd0);
    chk("midrst_mul_b", 64'(mb[0]), 64'd0);
    chk("midrst_res_valid", 64'(rv[0]), 64'd0);
    chk("midrst_res_data", rd[0], 64'd0);
    chk("midrst_res_ovf", 64'(ovf[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 16'd5, 16'd5, 1'b1);
    get_res(0, 64'd25, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
